// File: rtl/ahb_fir_feeder.sv
// AHB-Lite slave that buffers bus-written samples in a small FIFO and
// releases them to the FIR datapath at a programmable, divider-paced rate.
module ahb_fir_feeder #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int BIT_PREC = 16,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsel,
  input  logic                hready,
  input  logic [AWIDTH-1:0]   haddr,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [1:0]          htrans,
  input  logic [DWIDTH-1:0]   hwdata,
  output logic [DWIDTH-1:0]   hrdata,
  output logic                hreadyout,
  output logic                hresp,
  output logic [BIT_PREC-1:0] sample_out,
  output logic                sample_vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Address-phase capture (stage p0 feeds the data phase)
  logic [1:0] addr_p0;
  logic       write_p0;
  logic       vld_p0;

  // FIFO storage and bookkeeping
  logic [BIT_PREC-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  // Control/status registers and rate divider
  logic        en;
  logic [15:0] rate;
  logic [15:0] cnt;
  logic        ovf;
  logic        udr;

  // Decoded data-phase events
  logic wr_dp, rd_dp;
  logic push_req, ctrl_wr, rate_wr, stat_wr;
  logic clr, tc, pop, push_ok, ovf_evt, udr_evt;
  logic empty, full;

  // Bus fields this slave never looks at (upper address bits, size, htrans[0])
  logic unused_ok;
  assign unused_ok = ^{haddr, hsize, htrans, hwdata};

  // Zero-wait-state slave that never errors
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  assign wr_dp    = vld_p0 & write_p0;
  assign rd_dp    = vld_p0 & ~write_p0;
  assign push_req = wr_dp & (addr_p0 == 2'd0);
  assign ctrl_wr  = wr_dp & (addr_p0 == 2'd1);
  assign rate_wr  = wr_dp & (addr_p0 == 2'd2);
  assign stat_wr  = wr_dp & (addr_p0 == 2'd3);

  // CLR wins over a pop landing in the same cycle; a pop frees room for a push into a full FIFO
  assign clr     = ctrl_wr & hwdata[1];
  assign tc      = en & (cnt == rate);
  assign pop     = tc & ~empty & ~clr;
  assign udr_evt = tc & empty & ~clr;
  assign push_ok = push_req & (~full | pop);
  assign ovf_evt = push_req & full & ~pop;

  // Latch address-phase attributes whenever the bus advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      addr_p0  <= 2'd0;
      write_p0 <= 1'b0;
    end else if (hready) begin
      vld_p0   <= hsel & htrans[1];
      addr_p0  <= haddr[3:2];
      write_p0 <= hwrite;
    end
  end

  // Sample storage: write the low BIT_PREC bits of DATA on an accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= hwdata[BIT_PREC-1:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (pop && !push_ok) level <= level - 1'b1;
    end
  end

  // CTRL/RATE registers and sticky flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      rate <= 16'd0;
      ovf  <= 1'b0;
      udr  <= 1'b0;
    end else begin
      if (ctrl_wr) en   <= hwdata[0];
      if (rate_wr) rate <= hwdata[15:0];
      if (clr)                    ovf <= 1'b0;
      else if (ovf_evt)           ovf <= 1'b1;
      else if (stat_wr && hwdata[11]) ovf <= 1'b0;
      if (clr)                    udr <= 1'b0;
      else if (udr_evt)           udr <= 1'b1;
      else if (stat_wr && hwdata[12]) udr <= 1'b0;
    end
  end

  // Rate divider: counts 0..RATE while enabled, restarts on CLR or a RATE write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (clr || rate_wr || !en) begin
      cnt <= 16'd0;
    end else if (cnt == rate) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Output stage: present the popped head for one strobe, then hold it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= pop;
      if (pop) sample_out <= mem[rd_ptr];
    end
  end

  // Read mux, live only during a read data phase
  always_comb begin
    hrdata = '0;
    if (rd_dp) begin
      case (addr_p0)
        2'd1: hrdata[0]    = en;
        2'd2: hrdata[15:0] = rate;
        2'd3: begin
          hrdata[8:0] = 9'(level);
          hrdata[9]   = empty;
          hrdata[10]  = full;
          hrdata[11]  = ovf;
          hrdata[12]  = udr;
        end
        default: hrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_fir_feeder.sv
// Scoreboard bench for ahb_fir_feeder: bus tasks queue expected read data and
// samples; monitors on the falling edge pop and compare.
module tb_ahb_fir_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic        hready;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic [15:0] sample_out;
  logic        sample_vld;

  always #5 clk = ~clk;

  ahb_fir_feeder #(.DWIDTH(32), .AWIDTH(32), .BIT_PREC(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .hready(hready), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .sample_out(sample_out), .sample_vld(sample_vld)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_smp[$];
  logic [31:0] exp_rd[$];
  string       rd_nm[$];
  int          vld_cyc[$];
  bit          sb_on = 1'b1;
  int          cyc = 0;
  logic        rd_mon;
  logic [31:0] pend = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Track which cycles are read data phases, as the bus sees them
  always @(posedge clk or posedge rst) begin
    if (rst) rd_mon <= 1'b0;
    else if (hready) rd_mon <= hsel & htrans[1] & ~hwrite;
  end

  // Monitor: response signals, read data and sample strobes
  always @(negedge clk) begin
    if (!rst) begin
      chk("hreadyout", {31'h0, hreadyout}, 32'h1);
      chk("hresp", {31'h0, hresp}, 32'h0);
      if (rd_mon) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 32'h1, 32'h0);
        else chk(rd_nm.pop_front(), hrdata, exp_rd.pop_front());
      end
      if (sample_vld === 1'b1 && sb_on) begin
        vld_cyc.push_back(cyc);
        if (exp_smp.size() == 0) chk("unexpected_sample", {16'h0, sample_out}, 32'hFFFF_FFFF);
        else chk("sample", {16'h0, sample_out}, {16'h0, exp_smp.pop_front()});
      end
    end
  end

  // One bus cycle: new address phase plus the previous transfer's write data
  task automatic xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    hwdata = pend;
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = {28'h0, a};
    if (wr) pend = d;
    else begin
      pend = 32'h0;
      exp_rd.push_back(exp);
      rd_nm.push_back(nm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hwdata = pend;
      pend   = 32'h0;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
    end
  endtask

  task automatic wreg(input logic [3:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 32'h0, "");
  endtask

  task automatic rreg(input logic [3:0] a, input logic [31:0] exp, input string nm);
    xfer(1'b0, a, 32'h0, exp, nm);
  endtask

  task automatic wdata(input logic [15:0] v, input bit emit);
    xfer(1'b1, 4'h0, {16'hDEAD, v}, 32'h0, "");
    if (emit) exp_smp.push_back(v);
  endtask

  task automatic wait_drain(input int limit, input string nm);
    for (int i = 0; i < limit && exp_smp.size() != 0; i++) @(posedge clk);
    chk(nm, exp_smp.size(), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1; hsel = 1'b0; hready = 1'b1; haddr = 32'h0; hwrite = 1'b0;
    hsize = 3'b010; htrans = 2'b00; hwdata = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sample_vld", {31'h0, sample_vld}, 32'h0);
    chk("rst_sample_out", {16'h0, sample_out}, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
    chk("rst_hresp", {31'h0, hresp}, 32'h0);
    #1 rst = 1'b0;
    rreg(4'hC, 32'h0000_0200, "status_after_reset");
    idle(1);

    // Three samples at RATE=3, then underrun
    vld_cyc.delete();
    wdata(16'h1111, 1); wdata(16'h2222, 1); wdata(16'h3333, 1);
    wreg(4'h8, 32'd3);
    wreg(4'h4, 32'h1);
    idle(1);
    wait_drain(100, "drain_rate3");
    idle(8);
    rreg(4'hC, 32'h0000_1200, "status_udr");
    idle(1);
    chk("strobe_count", vld_cyc.size(), 32'd3);
    if (vld_cyc.size() == 3) begin
      chk("spacing_1", vld_cyc[1] - vld_cyc[0], 32'd4);
      chk("spacing_2", vld_cyc[2] - vld_cyc[1], 32'd4);
    end
    wreg(4'h4, 32'h0);
    wreg(4'hC, 32'h0000_1000);
    rreg(4'hC, 32'h0000_0200, "status_udr_cleared");
    idle(1);

    // Overflow: 17 back-to-back writes, the last one dropped
    for (int i = 0; i < 17; i++) wdata(16'h0100 + 16'(i), i < 16);
    idle(1);
    rreg(4'hC, 32'h0000_0C10, "status_full_ovf");
    wreg(4'hC, 32'h0000_0800);
    rreg(4'hC, 32'h0000_0410, "status_ovf_cleared");
    wreg(4'h8, 32'd0);
    // Enable and push in the very cycle of the first pop
    wreg(4'h4, 32'h1);
    wdata(16'hABCD, 1);
    rreg(4'hC, 32'h0000_0410, "status_push_with_pop");
    idle(1);
    wait_drain(100, "drain_full");
    idle(2);
    wreg(4'h4, 32'h0);
    wreg(4'hC, 32'h0000_1800);
    rreg(4'hC, 32'h0000_0200, "status_flags_cleared");
    idle(1);

    // CLR together with EN
    wreg(4'h8, 32'd50);
    for (int i = 0; i < 5; i++) wdata(16'h0A00 + 16'(i), 0);
    wreg(4'h4, 32'h3);
    rreg(4'hC, 32'h0000_0200, "status_after_clr");
    rreg(4'h4, 32'h0000_0001, "ctrl_readback");
    rreg(4'h8, 32'd50, "rate_readback");
    rreg(4'h0, 32'h0, "data_reads_zero");
    idle(20);
    wreg(4'h4, 32'h0);
    idle(1);

    // Asynchronous reset while a strobe is high
    sb_on = 1'b0;
    wreg(4'h8, 32'd0);
    for (int i = 0; i < 4; i++) wdata(16'h5A50 + 16'(i), 0);
    wreg(4'h4, 32'h1);
    idle(1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (sample_vld === 1'b1) got = 1'b1;
    end
    chk("vld_before_reset", {31'h0, got}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_sample_vld", {31'h0, sample_vld}, 32'h0);
    chk("async_rst_sample_out", {16'h0, sample_out}, 32'h0);
    chk("async_rst_hrdata", hrdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    sb_on = 1'b1;
    rreg(4'hC, 32'h0000_0200, "status_after_async_rst");
    rreg(4'h8, 32'h0, "rate_after_async_rst");
    rreg(4'h4, 32'h0, "ctrl_after_async_rst");
    idle(5);

    chk("pending_samples", exp_smp.size(), 32'h0);
    chk("pending_reads", exp_rd.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
